// File: rtl/ca_acq_pkg.sv
// ca_acq_pkg
// Types and constants shared by the C/A acquisition correlator:
//   state_e        - search controller states
//   CA_LEN         - C/A code period in chips
//   ACC_W_DEFAULT  - default signed correlation width (holds +/-1023)
//   LOSS_N_DEFAULT - default consecutive-miss count that drops lock
//   PHASE_W        - width of the slipped-chip counter
//   mag()          - two's-complement magnitude of a sign-extended value
package ca_acq_pkg;

  localparam int CA_LEN         = 1023;
  localparam int ACC_W_DEFAULT  = 12;
  localparam int LOSS_N_DEFAULT = 4;
  localparam int PHASE_W        = 10;
  localparam int MAG_W          = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_DWELL,
    ST_SLIP,
    ST_LOCK
  } state_e;

  // Callers sign-extend into MAG_W bits first, so the most negative
  // correlation value never reaches the negate.
  function automatic logic [MAG_W-1:0] mag(input logic signed [MAG_W-1:0] v);
    logic [MAG_W-1:0] r;
    r = v[MAG_W-1] ? $unsigned(-v) : $unsigned(v);
    return r;
  endfunction

endpackage

// File: rtl/ca_acq_correlator_integrator.sv
// ca_epoch_integrator
// Per-epoch +/-1 sign-agreement integrator.
//   clk, rst        - clock, asynchronous active-low reset
//   run             - accumulate (high whenever the search is active)
//   clear           - zero the accumulator (search (re)start), wins over run
//   dump_en         - an epoch edge in this cycle publishes the accumulator
//   sample_en       - chip strobe; sample_in / ca_code valid this cycle
//   sample_in       - front-end sign bit
//   ca_code         - local replica chip
//   epoch           - epoch level marker from the code generator
//   ep_edge         - rising edge of epoch (combinational)
//   acc             - running accumulator, i.e. the value that would be dumped
//   corr_val        - registered correlation of the last dumped epoch
//   corr_valid      - one-cycle pulse when corr_val updates
module ca_epoch_integrator
  import ca_acq_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    clear,
  input  logic                    dump_en,
  input  logic                    sample_en,
  input  logic                    sample_in,
  input  logic                    ca_code,
  input  logic                    epoch,
  output logic                    ep_edge,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] corr_val,
  output logic                    corr_valid
);

  localparam logic signed [ACC_W-1:0] CHIP_P = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] CHIP_N = ACC_W'(-1);

  logic                    epoch_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] corr_val_q, corr_val_d;
  logic                    corr_valid_q, corr_valid_d;
  logic signed [ACC_W-1:0] chip_val;

  // epoch may stay high for several cycles (e.g. when a chip advance is
  // suppressed); only its first cycle counts as a boundary.
  assign ep_edge = epoch & ~epoch_q;

  always_comb begin
    chip_val     = '0;
    acc_d        = acc_q;
    corr_val_d   = corr_val_q;
    corr_valid_d = 1'b0;
    if (sample_en) begin
      chip_val = (sample_in ~^ ca_code) ? CHIP_P : CHIP_N;
    end
    if (clear) begin
      acc_d = '0;
    end else if (run) begin
      if (ep_edge) begin
        // The chip arriving with the boundary opens the new epoch; the
        // dumped value is the accumulator before this cycle.
        acc_d = chip_val;
        if (dump_en) begin
          corr_val_d   = acc_q;
          corr_valid_d = 1'b1;
        end
      end else begin
        acc_d = acc_q + chip_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epoch_q      <= 1'b0;
      acc_q        <= '0;
      corr_val_q   <= '0;
      corr_valid_q <= 1'b0;
    end else begin
      epoch_q      <= epoch;
      acc_q        <= acc_d;
      corr_val_q   <= corr_val_d;
      corr_valid_q <= corr_valid_d;
    end
  end

  assign acc        = acc_q;
  assign corr_val   = corr_val_q;
  assign corr_valid = corr_valid_q;

endmodule

// File: rtl/ca_acq_correlator.sv
// ca_acq_correlator
// Serial-search acquisition for one GPS C/A channel. Integrates sign
// agreement over each code epoch, tests |correlation| against thresh and
// requests a one-chip replica slip after every failed dwell.
//   clk, rst     - clock, asynchronous active-low reset
//   sample_in    - front-end sign bit (1 = +1)
//   sample_en    - chip strobe
//   ca_code      - replica chip
//   epoch        - code-generator epoch level marker
//   start        - begin (or restart) a search from phase 0
//   thresh       - unsigned detection threshold on |correlation|
//   slip         - one-cycle request to delay the replica by one chip
//   corr_val     - signed correlation of the last complete epoch
//   corr_valid   - one-cycle pulse when corr_val updates
//   phase        - chips slipped since start
//   busy         - search active (any state but IDLE)
//   locked       - in LOCK
//   fail         - sticky: every code phase tried without detection
module ca_acq_correlator
  import ca_acq_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEFAULT,
  parameter int LOSS_N = LOSS_N_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_in,
  input  logic                    sample_en,
  input  logic                    ca_code,
  input  logic                    epoch,
  input  logic                    start,
  input  logic [ACC_W-2:0]        thresh,
  output logic                    slip,
  output logic signed [ACC_W-1:0] corr_val,
  output logic                    corr_valid,
  output logic [PHASE_W-1:0]      phase,
  output logic                    busy,
  output logic                    locked,
  output logic                    fail
);

  localparam int                 LOSS_W     = $clog2(LOSS_N + 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CA_LEN - 1);

  state_e                  state_q, state_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [LOSS_W-1:0]       loss_q, loss_d;
  logic                    fail_q, fail_d;
  logic                    slip_q, slip_d;

  logic                    ep_edge;
  logic signed [ACC_W-1:0] acc;
  logic                    run;
  logic                    dump_en;
  logic                    hit;

  assign run     = (state_q != ST_IDLE);
  assign dump_en = (state_q == ST_DWELL) || (state_q == ST_LOCK);

  // Decision uses the accumulator that is being dumped this cycle, so the
  // state change lands together with corr_valid.
  assign hit = mag(MAG_W'(acc)) >= MAG_W'(thresh);

  ca_epoch_integrator #(
    .ACC_W (ACC_W)
  ) u_integrator (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .clear      (start),
    .dump_en    (dump_en),
    .sample_en  (sample_en),
    .sample_in  (sample_in),
    .ca_code    (ca_code),
    .epoch      (epoch),
    .ep_edge    (ep_edge),
    .acc        (acc),
    .corr_val   (corr_val),
    .corr_valid (corr_valid)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    loss_d  = loss_q;
    fail_d  = fail_q;
    slip_d  = 1'b0;
    if (start) begin
      // Restart from any state; a coincident epoch edge is ignored.
      state_d = ST_ALIGN;
      phase_d = '0;
      loss_d  = '0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_ALIGN: begin
          // The epoch in progress is partial; measure from the next one.
          if (ep_edge) state_d = ST_DWELL;
        end
        ST_DWELL: begin
          if (ep_edge) begin
            if (hit) begin
              state_d = ST_LOCK;
              loss_d  = '0;
            end else if (phase_q == PHASE_LAST) begin
              state_d = ST_IDLE;
              fail_d  = 1'b1;
            end else begin
              state_d = ST_SLIP;
            end
          end
        end
        ST_SLIP: begin
          slip_d  = 1'b1;
          phase_d = phase_q + PHASE_W'(1);
          state_d = ST_ALIGN;
        end
        ST_LOCK: begin
          if (ep_edge) begin
            if (hit) begin
              loss_d = '0;
            end else if (loss_q == LOSS_W'(LOSS_N - 1)) begin
              state_d = ST_IDLE;
              loss_d  = '0;
            end else begin
              loss_d = loss_q + LOSS_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      loss_q  <= '0;
      fail_q  <= 1'b0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      loss_q  <= loss_d;
      fail_q  <= fail_d;
      slip_q  <= slip_d;
    end
  end

  assign slip   = slip_q;
  assign phase  = phase_q;
  assign fail   = fail_q;
  assign busy   = (state_q != ST_IDLE);
  assign locked = (state_q == ST_LOCK);

endmodule

// File: tb/tb_ca_acq_correlator.sv
// tb_ca_acq_correlator
// Random-code replica generator with slip handling, a signal source with a
// programmable chip delay, and an epoch-level acquisition model feeding a
// scoreboard that a separate monitor drains on corr_valid.
module tb_ca_acq_correlator;
  import ca_acq_pkg::*;

  localparam int AW   = 12;
  localparam int LOSS = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 sample_in, sample_en, ca_code, epoch, start;
  logic [AW-2:0]        thresh;
  logic                 slip, corr_valid, busy, locked, fail;
  logic signed [AW-1:0] corr_val;
  logic [9:0]           phase;

  always #5 clk = ~clk;

  ca_acq_correlator #(.ACC_W(AW), .LOSS_N(LOSS)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_en(sample_en),
    .ca_code(ca_code), .epoch(epoch), .start(start), .thresh(thresh),
    .slip(slip), .corr_val(corr_val), .corr_valid(corr_valid), .phase(phase),
    .busy(busy), .locked(locked), .fail(fail)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {int corr; int lk; int ph;} exp_t;
  exp_t exp_q[$];

  // code generator / signal source
  bit code [0:1022];
  int L, rep, sig, src;
  bit last_en, pend;
  int th_lo, th_hi;
  bit start_req, start_on_rise, rel_pending;

  // acquisition model
  typedef enum {S_OFF, S_WAIT_EPOCH, S_MEASURE, S_STEP, S_TRACK} mmode_t;
  mmode_t mode;
  int m_sum, m_phase, m_loss, m_dumps, exp_slips, slip_seen;
  bit m_fail, m_prev_ep;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_slip"}, int'(slip), 0);
    check({tag, "_corr_val"}, int'(corr_val), 0);
    check({tag, "_corr_valid"}, int'(corr_valid), 0);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_fail"}, int'(fail), 0);
  endtask

  function automatic void setup(input int len, input int delay);
    L = len;
    for (int i = 0; i < 1023; i++) code[i] = 1'($urandom_range(0, 1));
    rep = 0;
    sig = (L - delay) % L;
    pend = 0;
    last_en = 0;
    src = 0;
  endfunction

  function automatic void model_reset();
    mode = S_OFF; m_sum = 0; m_phase = 0; m_loss = 0; m_fail = 0; m_prev_ep = 0;
    exp_q.delete();
  endfunction

  function automatic void push_dump(input int lk);
    exp_t e;
    e.corr = m_sum; e.lk = lk; e.ph = m_phase;
    exp_q.push_back(e);
    m_dumps++;
  endfunction

  // One clock: advance the generators for the chip just consumed, drive the
  // next cycle's inputs, and step the model for the coming edge.
  task automatic tick();
    bit rise, hit;
    int chip, a;
    mmode_t prev;
    @(negedge clk);
    if (last_en) begin
      if (pend) pend = 0; else rep = (rep + 1) % L;
      sig = (sig + 1) % L;
    end
    if (slip) pend = 1;
    sample_en = ($urandom_range(0, 9) != 0);
    last_en   = sample_en;
    ca_code   = code[rep];
    epoch     = (rep == 0);
    case (src)
      0:       sample_in = code[sig];
      1:       sample_in = ~code[sig];
      default: sample_in = 1'($urandom_range(0, 1));
    endcase
    if (mode != S_OFF && $urandom_range(0, 399) == 0)
      thresh = (AW-1)'($urandom_range(th_lo, th_hi));
    if (rel_pending) begin rst = 1'b1; rel_pending = 0; end
    rise  = epoch && !m_prev_ep;
    start = start_req || (start_on_rise && rise);
    if (start) begin start_req = 0; start_on_rise = 0; end
    if (rst) begin
      chip = !sample_en ? 0 : (sample_in == ca_code) ? 1 : -1;
      prev = mode;
      if (start) begin
        mode = S_WAIT_EPOCH; m_phase = 0; m_fail = 0; m_loss = 0; m_sum = 0;
      end else if (mode != S_OFF) begin
        if (rise) begin
          a = (m_sum < 0) ? -m_sum : m_sum;
          hit = (a >= int'(thresh));
          case (mode)
            S_WAIT_EPOCH: mode = S_MEASURE;
            S_MEASURE: begin
              if (hit) begin push_dump(1); mode = S_TRACK; m_loss = 0; end
              else if (m_phase == CA_LEN - 1) begin push_dump(0); mode = S_OFF; m_fail = 1; end
              else begin push_dump(0); mode = S_STEP; end
            end
            S_TRACK: begin
              if (hit) begin m_loss = 0; push_dump(1); end
              else begin
                m_loss++;
                if (m_loss == LOSS) begin mode = S_OFF; push_dump(0); end
                else push_dump(1);
              end
            end
            default: ;
          endcase
          m_sum = chip;
        end else begin
          m_sum += chip;
        end
        if (prev == S_STEP) begin mode = S_WAIT_EPOCH; m_phase++; exp_slips++; end
      end
      m_prev_ep = epoch;
    end else begin
      m_prev_ep = 0;
    end
  endtask

  // monitor: one line per dump, compared against the scoreboard
  initial begin
    exp_t e;
    int dump_no;
    dump_no = 0;
    forever begin
      @(negedge clk);
      if (slip) slip_seen++;
      if (corr_valid) begin
        dump_no++;
        $display("dump %0d corr_val=%0d locked=%0d phase=%0d", dump_no, corr_val, locked, phase);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_corr_valid got corr_val=%0d want no dump", corr_val);
        end else begin
          e = exp_q.pop_front();
          check("dump_corr_val", int'(corr_val), e.corr);
          check("dump_locked", int'(locked), e.lk);
          check("dump_phase", int'(phase), e.ph);
        end
      end
    end
  end

  initial begin
    int n, d0, s0, s1;
    rst = 1'b0; sample_in = 0; sample_en = 0; ca_code = 0; epoch = 0; start = 0;
    thresh = 11'd900; th_lo = 900; th_hi = 1023;
    start_req = 0; start_on_rise = 0; rel_pending = 0;
    slip_seen = 0; exp_slips = 0; m_dumps = 0;
    model_reset();
    setup(1023, 0);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_init");
    rel_pending = 1;
    repeat (3) tick();
    check("idle_busy", int'(busy), 0);

    // T1: zero offset -> lock at phase 0, then data inversion, then loss
    setup(1023, 0); thresh = 11'd900; start_req = 1;
    n = 0; while (!locked && n < 5000) begin tick(); n++; end
    check("t1_lock_in_time", int'(n < 5000), 1);
    repeat (2) tick();
    check("t1_corr_val", int'(corr_val), 1023);
    check("t1_phase", int'(phase), 0);
    check("t1_slips", slip_seen, 0);
    src = 1; d0 = m_dumps;
    n = 0; while (m_dumps < d0 + 3 && n < 8000) begin tick(); n++; end
    repeat (3) tick();
    check("t1_inv_corr", int'(corr_val), -1023);
    check("t1_inv_locked", int'(locked), 1);
    src = 2;
    n = 0; while (busy && n < 10000) begin tick(); n++; end
    check("t1_loss_in_time", int'(n < 10000), 1);
    check("t1_loss_locked", int'(locked), 0);
    check("t1_loss_fail", int'(fail), 0);

    // T2: signal 5 chips behind the replica -> five slips then lock
    setup(1023, 5); thresh = (AW-1)'($urandom_range(900, 1023)); start_req = 1;
    s0 = slip_seen;
    n = 0; while (!locked && n < 25000) begin tick(); n++; end
    check("t2_lock_in_time", int'(n < 25000), 1);
    repeat (3) tick();
    check("t2_phase", int'(phase), 5);
    check("t2_slips", slip_seen - s0, 5);
    check("t2_corr_val", int'(corr_val), 1023);

    // T3: asynchronous reset mid-dwell, then start coincident with an epoch edge
    src = 2; n = 0; while (busy && n < 10000) begin tick(); n++; end
    setup(63, 3); th_lo = 50; th_hi = 63; thresh = 11'd55; start_req = 1;
    n = 0; while (!(mode == S_MEASURE && m_phase >= 1) && n < 3000) begin tick(); n++; end
    check("t3_dwell_reached", int'(n < 3000), 1);
    repeat (10) tick();
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_mid");
    model_reset();
    repeat (2) tick();
    rel_pending = 1;
    repeat (3) tick();
    setup(63, 3); start_on_rise = 1;
    n = 0; while (!locked && n < 3000) begin tick(); n++; end
    check("t3_lock_in_time", int'(n < 3000), 1);
    repeat (3) tick();
    check("t3_phase", int'(phase), 3);
    check("t3_corr_val", int'(corr_val), 63);

    // T4: noise -> restart mid-search, then exhaustive search ends in fail
    src = 2; n = 0; while (busy && n < 3000) begin tick(); n++; end
    setup(11, 0); src = 2; th_lo = 900; th_hi = 1023; thresh = 11'd1000; start_req = 1;
    s0 = slip_seen;
    n = 0; while (slip_seen - s0 < 40 && n < 5000) begin tick(); n++; end
    start_req = 1;
    repeat (3) tick();
    check("t4_restart_phase", int'(phase), 0);
    s1 = slip_seen;
    n = 0; while (!fail && n < 60000) begin tick(); n++; end
    check("t4_fail_in_time", int'(n < 60000), 1);
    repeat (5) tick();
    check("t4_fail", int'(fail), 1);
    check("t4_busy", int'(busy), 0);
    check("t4_locked", int'(locked), 0);
    check("t4_phase", int'(phase), CA_LEN - 1);
    check("t4_slips", slip_seen - s1, CA_LEN - 1);

    check("scoreboard_drained", exp_q.size(), 0);
    check("slip_total", slip_seen, exp_slips);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
